// File: rtl/parity_window_counter.sv
// Streaming even/odd classifier: flags each accepted sample one cycle later and
// emits an even/odd count report on a second handshake after every WINDOW samples.
module parity_window_counter #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 16,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             even,
  output logic             odd,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_even,
  output logic [CNT_W-1:0] rpt_odd
);

  logic [CNT_W-1:0] e_cnt;
  logic [CNT_W-1:0] o_cnt;
  logic [CNT_W-1:0] s_cnt;
  logic             is_even;
  logic             last;
  logic             accept;
  logic             rpt_take;

  assign is_even  = mode ? ~(^in_data) : ~in_data[0];
  assign last     = (s_cnt == CNT_W'(WINDOW - 1));
  // Stall only when this sample would complete a window whose report slot is still occupied.
  assign in_ready = ~clear & ~(rpt_valid & ~rpt_ready & last);
  assign accept   = in_valid & in_ready;
  assign rpt_take = rpt_valid & rpt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      even      <= 1'b0;
      odd       <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_even  <= '0;
      rpt_odd   <= '0;
      e_cnt     <= '0;
      o_cnt     <= '0;
      s_cnt     <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      rpt_valid <= 1'b0;
      e_cnt     <= '0;
      o_cnt     <= '0;
      s_cnt     <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        even <= is_even;
        odd  <= ~is_even;
      end
      // A completing accept reloads the report even when the old one is taken in the same cycle.
      if (accept && last) begin
        rpt_even  <= e_cnt + CNT_W'(is_even);
        rpt_odd   <= o_cnt + CNT_W'(~is_even);
        rpt_valid <= 1'b1;
        e_cnt     <= '0;
        o_cnt     <= '0;
        s_cnt     <= '0;
      end else begin
        if (rpt_take)
          rpt_valid <= 1'b0;
        if (accept) begin
          s_cnt <= s_cnt + 1'b1;
          e_cnt <= e_cnt + CNT_W'(is_even);
          o_cnt <= o_cnt + CNT_W'(~is_even);
        end
      end
    end
  end

endmodule
